ibex_rf_writeback_stage: RTL and testbench
==========================================

Name: ibex_rf_writeback_stage

Overview:
- Writeback stage directly upstream of the register file write port.
- Accepts retiring instructions from EX: ALU results, and loads whose data arrives later from the LSU.
- Drives the single write port (waddr/wdata/we) plus the dummy_instr_wb flag. Exposes a busy/forwarding view so ID can detect hazards against the pending destination register.

Parameters:
- RV32E, 0: when 1, rd addresses 16-31 are illegal; the write is suppressed and flagged.
- DataWidth, 32: width of write data.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_valid_i  in  1  EX presents a retiring instruction
- instr_ready_o  out  1  WB can accept this cycle
- rd_addr_i  in  5  destination register
- rd_we_i  in  1  instruction writes rd
- rd_data_i  in  DataWidth  ALU result (ignored for loads)
- is_load_i  in  1  result comes from LSU response
- dummy_instr_i  in  1  instruction is a dummy instruction
- lsu_resp_valid_i  in  1  load response strobe
- lsu_resp_data_i  in  DataWidth  load data
- lsu_resp_err_i  in  1  load bus error
- rf_waddr_o  out  5  to register file waddr_a_i
- rf_wdata_o  out  DataWidth  to register file wdata_a_i
- rf_we_o  out  1  to register file we_a_i
- dummy_instr_wb_o  out  1  to register file dummy_instr_wb_i
- rd_busy_o  out  1  a load to rd_busy_addr_o is outstanding
- rd_busy_addr_o  out  5  pending load destination
- wb_done_o  out  1  instruction retired this cycle
- load_err_o  out  1  load retired with error, write dropped
- rv32e_err_o  out  1  illegal rd under RV32E, write dropped

Behaviour:
- Clock is clk_i. Reset rst_ni is asynchronous, active-low.
- States: IDLE, WB, WAIT_LSU.
- Reset: state=IDLE; all captured fields (rd, data, we, dummy, err) = 0.
- Outputs during and after reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, dummy_instr_wb_o=0, rd_busy_o=0, rd_busy_addr_o=0, wb_done_o=0, load_err_o=0, rv32e_err_o=0, instr_ready_o=1.
- instr_ready_o = (state != WAIT_LSU). It is combinational from the state only, not from inputs.
- Accept: instr_valid_i & instr_ready_o captures rd, rd_we, rd_data, is_load, dummy.
  - Next state is WAIT_LSU if is_load_i, else WB.
- IDLE: no write. Without accept, stay in IDLE.
- WB lasts exactly one cycle per instruction:
  - wb_done_o=1.
  - rf_waddr_o = captured rd.
  - rf_wdata_o = captured data.
  - dummy_instr_wb_o = captured dummy.
  - rf_we_o = we & (rd != 0) & !load_err & !rv32e_err.
  - load_err_o = captured LSU err.
  - rv32e_err_o = RV32E & we & rd[4].
  - Next state: a new accept in the same cycle goes to WB or WAIT_LSU (back-to-back, no bubble); otherwise IDLE.
- Latency: an ALU instruction accepted at edge N is written in cycle N+1. Throughput is 1 per cycle.
- WAIT_LSU:
  - rd_busy_o = captured we & (rd != 0); rd_busy_addr_o = captured rd.
  - On lsu_resp_valid_i, capture lsu_resp_data_i and lsu_resp_err_i, then go to WB. The write occurs the cycle after the response.
- rd_busy_o and rd_busy_addr_o are 0 outside WAIT_LSU.
- rf_waddr_o, rf_wdata_o and dummy_instr_wb_o are 0 outside WB.
- lsu_resp_valid_i in IDLE or WB (no outstanding load) is ignored with no state change.
- Reset asserted mid-WAIT_LSU drops the load; no write. A response arriving after reset release is ignored.
- x0 writes are never forwarded to the register file. wb_done_o still pulses.

Test Plan:
- ALU back-to-back: accept (rd=5, 0xDEADBEEF) at cycle 0 and (rd=6, 0x00000001) at cycle 1 -> rf_we_o=1 in cycles 1 and 2 with matching addr/data; instr_ready_o stays 1.
- x0 write: accept rd=0, data=0xFFFFFFFF, rd_we=1 -> rf_we_o=0, wb_done_o=1 for one cycle.
- Load: accept is_load, rd=10; lsu_resp_valid_i 3 cycles later with 0x12345678 -> instr_ready_o=0 and rd_busy_o=1 (addr 10) until the response; rf_we_o=1 with rd=10, 0x12345678 the next cycle; then ready=1.
- Load error: as above with lsu_resp_err_i=1 -> rf_we_o=0, load_err_o=1, wb_done_o=1 for one cycle.
- RV32E=1: accept rd=17, rd_we=1 -> rf_we_o=0, rv32e_err_o=1. Also accept rd=15 with dummy_instr_i=1 -> rf_we_o=1 and dummy_instr_wb_o=1.
- Reset in WAIT_LSU: assert rst_ni=0 while waiting on rd=3, release, then pulse lsu_resp_valid_i -> no rf_we_o, state IDLE, rd_busy_o=0.

Source files
------------

// File: rtl/ibex_rf_writeback_stage.sv
// Writeback stage in front of the register-file write port: retires ALU results
// directly and holds loads until the LSU response arrives, exposing the pending rd to ID.
module ibex_rf_writeback_stage #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [4:0]           rd_addr_i,
    input  logic                 rd_we_i,
    input  logic [DataWidth-1:0] rd_data_i,
    input  logic                 is_load_i,
    input  logic                 dummy_instr_i,

    input  logic                 lsu_resp_valid_i,
    input  logic [DataWidth-1:0] lsu_resp_data_i,
    input  logic                 lsu_resp_err_i,

    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 dummy_instr_wb_o,

    output logic                 rd_busy_o,
    output logic [4:0]           rd_busy_addr_o,
    output logic                 wb_done_o,
    output logic                 load_err_o,
    output logic                 rv32e_err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WB       = 2'd1,
        WAIT_LSU = 2'd2
    } wb_state_e;

    wb_state_e            state_reg;
    logic [4:0]           rd_reg;
    logic [DataWidth-1:0] data_reg;
    logic                 we_reg;
    logic                 dummy_reg;
    logic                 err_reg;

    logic accept;
    logic in_wb;
    logic in_wait;
    logic rv32e_bad;

    assign instr_ready_o = (state_reg != WAIT_LSU);
    assign accept        = instr_valid_i & instr_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            rd_reg    <= '0;
            data_reg  <= '0;
            we_reg    <= 1'b0;
            dummy_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, WB: begin
                    // A new accept in WB overwrites the retiring entry: no bubble.
                    if (accept) begin
                        rd_reg    <= rd_addr_i;
                        data_reg  <= rd_data_i;
                        we_reg    <= rd_we_i;
                        dummy_reg <= dummy_instr_i;
                        err_reg   <= 1'b0;
                        state_reg <= is_load_i ? WAIT_LSU : WB;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                WAIT_LSU: begin
                    if (lsu_resp_valid_i) begin
                        data_reg  <= lsu_resp_data_i;
                        err_reg   <= lsu_resp_err_i;
                        state_reg <= WB;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_wb     = (state_reg == WB);
    assign in_wait   = (state_reg == WAIT_LSU);
    assign rv32e_bad = RV32E & we_reg & rd_reg[4];

    // Write port is decoded purely from registered state, so it never sees input glitches.
    assign wb_done_o        = in_wb;
    assign rf_we_o          = in_wb & we_reg & (rd_reg != 5'd0) & ~err_reg & ~rv32e_bad;
    assign rf_waddr_o       = in_wb ? rd_reg : 5'd0;
    assign rf_wdata_o       = in_wb ? data_reg : '0;
    assign dummy_instr_wb_o = in_wb & dummy_reg;
    assign load_err_o       = in_wb & err_reg;
    assign rv32e_err_o      = in_wb & rv32e_bad;

    assign rd_busy_o      = in_wait & we_reg & (rd_reg != 5'd0);
    assign rd_busy_addr_o = in_wait ? rd_reg : 5'd0;

endmodule

// File: tb/tb_ibex_rf_writeback_stage.sv
// Bench for ibex_rf_writeback_stage (RV32E=1): timing checked inline per scenario,
// retired writes collected by a monitor and matched against an expected-write queue.
module tb_ibex_rf_writeback_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic [31:0] rd_data_i;
    logic        is_load_i;
    logic        dummy_instr_i;
    logic        lsu_resp_valid_i;
    logic [31:0] lsu_resp_data_i;
    logic        lsu_resp_err_i;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_we_o;
    logic        dummy_instr_wb_o;
    logic        rd_busy_o;
    logic [4:0]  rd_busy_addr_o;
    logic        wb_done_o;
    logic        load_err_o;
    logic        rv32e_err_o;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        we;
        logic        dummy;
        logic        lerr;
        logic        rerr;
    } wb_t;

    wb_t exp_q[$];
    wb_t obs_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    ibex_rf_writeback_stage #(.RV32E(1'b1), .DataWidth(32)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .instr_valid_i    (instr_valid_i),
        .instr_ready_o    (instr_ready_o),
        .rd_addr_i        (rd_addr_i),
        .rd_we_i          (rd_we_i),
        .rd_data_i        (rd_data_i),
        .is_load_i        (is_load_i),
        .dummy_instr_i    (dummy_instr_i),
        .lsu_resp_valid_i (lsu_resp_valid_i),
        .lsu_resp_data_i  (lsu_resp_data_i),
        .lsu_resp_err_i   (lsu_resp_err_i),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .rf_we_o          (rf_we_o),
        .dummy_instr_wb_o (dummy_instr_wb_o),
        .rd_busy_o        (rd_busy_o),
        .rd_busy_addr_o   (rd_busy_addr_o),
        .wb_done_o        (wb_done_o),
        .load_err_o       (load_err_o),
        .rv32e_err_o      (rv32e_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: record every retired instruction as the DUT presents it.
    always @(negedge clk_i) begin
        if (rst_ni && wb_done_o) begin
            wb_t o;
            o.addr = rf_waddr_o; o.data = rf_wdata_o; o.we = rf_we_o;
            o.dummy = dummy_instr_wb_o; o.lerr = load_err_o; o.rerr = rv32e_err_o;
            obs_q.push_back(o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d, input logic we,
                            input logic dm, input logic le, input logic re);
        wb_t e;
        e.addr = a; e.data = d; e.we = we; e.dummy = dm; e.lerr = le; e.rerr = re;
        exp_q.push_back(e);
    endtask

    task automatic drive_instr(input logic [4:0] rd, input logic we, input logic [31:0] d,
                               input logic ld, input logic dm);
        instr_valid_i = 1'b1; rd_addr_i = rd; rd_we_i = we; rd_data_i = d;
        is_load_i = ld; dummy_instr_i = dm;
    endtask

    task automatic idle_instr();
        instr_valid_i = 1'b0; rd_addr_i = 5'd0; rd_we_i = 1'b0; rd_data_i = 32'h0;
        is_load_i = 1'b0; dummy_instr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_instr();
        lsu_resp_valid_i = 1'b0; lsu_resp_data_i = 32'h0; lsu_resp_err_i = 1'b0;
        tick(); tick();
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", rf_we_o); end
        n_checks++; if (rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr_data got=%0d/%h exp=0/0", rf_waddr_o, rf_wdata_o); end
        n_checks++; if ({dummy_instr_wb_o, rd_busy_o, wb_done_o, load_err_o, rv32e_err_o} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=00000", {dummy_instr_wb_o, rd_busy_o, wb_done_o, load_err_o, rv32e_err_o}); end
        n_checks++; if (rd_busy_addr_o !== 5'd0) begin n_fail++; $display("FAIL reset_busy_addr got=%0d exp=0", rd_busy_addr_o); end
        n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", instr_ready_o); end
        rst_ni = 1'b1;
        tick();
        n_checks++; if (wb_done_o !== 1'b0 || instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle got done=%b ready=%b exp done=0 ready=1", wb_done_o, instr_ready_o); end
    endtask

    task automatic test_alu_back_to_back();
        drive_instr(5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        push_exp(5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu0_write got we=%b rd=%0d d=%h exp we=1 rd=5 d=deadbeef", rf_we_o, rf_waddr_o, rf_wdata_o); end
        n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL alu0_ready got=%b exp=1", instr_ready_o); end
        drive_instr(5'd6, 1'b1, 32'h00000001, 1'b0, 1'b0);
        push_exp(5'd6, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd6 || rf_wdata_o !== 32'h1) begin n_fail++; $display("FAIL alu1_write got we=%b rd=%0d d=%h exp we=1 rd=6 d=00000001", rf_we_o, rf_waddr_o, rf_wdata_o); end
        n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL alu1_ready got=%b exp=1", instr_ready_o); end
        idle_instr();
        tick();
        n_checks++; if (wb_done_o !== 1'b0 || rf_we_o !== 1'b0 || rf_wdata_o !== 32'h0) begin n_fail++; $display("FAIL alu_idle got done=%b we=%b d=%h exp 0/0/0", wb_done_o, rf_we_o, rf_wdata_o); end
    endtask

    task automatic test_x0_write();
        drive_instr(5'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        push_exp(5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle_instr();
        n_checks++; if (rf_we_o !== 1'b0 || wb_done_o !== 1'b1) begin n_fail++; $display("FAIL x0_write got we=%b done=%b exp we=0 done=1", rf_we_o, wb_done_o); end
        tick();
        n_checks++; if (wb_done_o !== 1'b0) begin n_fail++; $display("FAIL x0_single_pulse got done=%b exp=0", wb_done_o); end
    endtask

    task automatic test_load(input logic err, input logic [4:0] rd, input logic [31:0] d);
        drive_instr(rd, 1'b1, 32'hAAAA5555, 1'b1, 1'b0);
        push_exp(rd, d, !err, 1'b0, err, 1'b0);
        tick();
        idle_instr();
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (instr_ready_o !== 1'b0 || rd_busy_o !== 1'b1 || rd_busy_addr_o !== rd) begin n_fail++; $display("FAIL load_wait%0d got ready=%b busy=%b addr=%0d exp ready=0 busy=1 addr=%0d", i, instr_ready_o, rd_busy_o, rd_busy_addr_o, rd); end
            n_checks++; if (wb_done_o !== 1'b0) begin n_fail++; $display("FAIL load_wait%0d_done got=%b exp=0", i, wb_done_o); end
            tick();
        end
        lsu_resp_valid_i = 1'b1; lsu_resp_data_i = d; lsu_resp_err_i = err;
        n_checks++; if (rd_busy_o !== 1'b1) begin n_fail++; $display("FAIL load_busy_at_resp got=%b exp=1", rd_busy_o); end
        tick();
        lsu_resp_valid_i = 1'b0; lsu_resp_data_i = 32'h0; lsu_resp_err_i = 1'b0;
        n_checks++; if (rf_we_o !== !err || rf_waddr_o !== rd || rf_wdata_o !== d) begin n_fail++; $display("FAIL load_write got we=%b rd=%0d d=%h exp we=%b rd=%0d d=%h", rf_we_o, rf_waddr_o, rf_wdata_o, !err, rd, d); end
        n_checks++; if (load_err_o !== err || wb_done_o !== 1'b1) begin n_fail++; $display("FAIL load_flags got err=%b done=%b exp err=%b done=1", load_err_o, wb_done_o, err); end
        n_checks++; if (instr_ready_o !== 1'b1 || rd_busy_o !== 1'b0 || rd_busy_addr_o !== 5'd0) begin n_fail++; $display("FAIL load_release got ready=%b busy=%b addr=%0d exp 1/0/0", instr_ready_o, rd_busy_o, rd_busy_addr_o); end
        if (!err) begin
            // ALU instruction accepted in the load's WB cycle follows with no bubble.
            drive_instr(5'd12, 1'b1, 32'h00000055, 1'b0, 1'b0);
            push_exp(5'd12, 32'h00000055, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        idle_instr();
        if (!err) begin
            n_checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd12 || rf_wdata_o !== 32'h55) begin n_fail++; $display("FAIL load_then_alu got we=%b rd=%0d d=%h exp we=1 rd=12 d=00000055", rf_we_o, rf_waddr_o, rf_wdata_o); end
            tick();
        end
        n_checks++; if (wb_done_o !== 1'b0 || load_err_o !== 1'b0) begin n_fail++; $display("FAIL load_end got done=%b err=%b exp 0/0", wb_done_o, load_err_o); end
    endtask

    task automatic test_stray_resp();
        lsu_resp_valid_i = 1'b1; lsu_resp_data_i = 32'h0BAD0BAD; lsu_resp_err_i = 1'b1;
        tick();
        lsu_resp_valid_i = 1'b0; lsu_resp_data_i = 32'h0; lsu_resp_err_i = 1'b0;
        n_checks++; if (wb_done_o !== 1'b0 || rf_we_o !== 1'b0 || instr_ready_o !== 1'b1 || load_err_o !== 1'b0) begin n_fail++; $display("FAIL stray_resp got done=%b we=%b ready=%b err=%b exp 0/0/1/0", wb_done_o, rf_we_o, instr_ready_o, load_err_o); end
    endtask

    task automatic test_rv32e();
        drive_instr(5'd17, 1'b1, 32'h11112222, 1'b0, 1'b0);
        push_exp(5'd17, 32'h11112222, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++; if (rf_we_o !== 1'b0 || rv32e_err_o !== 1'b1) begin n_fail++; $display("FAIL rv32e_rd17 got we=%b rverr=%b exp we=0 rverr=1", rf_we_o, rv32e_err_o); end
        drive_instr(5'd15, 1'b1, 32'h33334444, 1'b0, 1'b1);
        push_exp(5'd15, 32'h33334444, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle_instr();
        n_checks++; if (rf_we_o !== 1'b1 || dummy_instr_wb_o !== 1'b1 || rv32e_err_o !== 1'b0 || rf_waddr_o !== 5'd15) begin n_fail++; $display("FAIL rv32e_rd15_dummy got we=%b dummy=%b rverr=%b rd=%0d exp 1/1/0/15", rf_we_o, dummy_instr_wb_o, rv32e_err_o, rf_waddr_o); end
        drive_instr(5'd20, 1'b0, 32'h5, 1'b0, 1'b0);
        push_exp(5'd20, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle_instr();
        n_checks++; if (rv32e_err_o !== 1'b0 || dummy_instr_wb_o !== 1'b0) begin n_fail++; $display("FAIL rv32e_no_we got rverr=%b dummy=%b exp 0/0", rv32e_err_o, dummy_instr_wb_o); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        drive_instr(5'd3, 1'b1, 32'h0, 1'b1, 1'b0);
        tick();
        idle_instr();
        n_checks++; if (rd_busy_o !== 1'b1 || rd_busy_addr_o !== 5'd3) begin n_fail++; $display("FAIL rstwait_busy got busy=%b addr=%0d exp 1/3", rd_busy_o, rd_busy_addr_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_checks++; if (rd_busy_o !== 1'b0 || instr_ready_o !== 1'b1 || rd_busy_addr_o !== 5'd0) begin n_fail++; $display("FAIL rstwait_async got busy=%b ready=%b addr=%0d exp 0/1/0", rd_busy_o, instr_ready_o, rd_busy_addr_o); end
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        lsu_resp_valid_i = 1'b1; lsu_resp_data_i = 32'h77777777; lsu_resp_err_i = 1'b0;
        tick();
        lsu_resp_valid_i = 1'b0; lsu_resp_data_i = 32'h0;
        n_checks++; if (rf_we_o !== 1'b0 || wb_done_o !== 1'b0) begin n_fail++; $display("FAIL rstwait_no_write got we=%b done=%b exp 0/0", rf_we_o, wb_done_o); end
        n_checks++; if (rd_busy_o !== 1'b0 || instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstwait_idle got busy=%b ready=%b exp 0/1", rd_busy_o, instr_ready_o); end
        tick();
        n_checks++; if (wb_done_o !== 1'b0) begin n_fail++; $display("FAIL rstwait_late got done=%b exp=0", wb_done_o); end
    endtask

    task automatic test_scoreboard();
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sb_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wb_t e;
            wb_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.we !== e.we || o.dummy !== e.dummy || o.lerr !== e.lerr || o.rerr !== e.rerr) begin
                n_fail++;
                $display("FAIL sb_entry got rd=%0d d=%h we=%b dm=%b le=%b re=%b exp rd=%0d d=%h we=%b dm=%b le=%b re=%b",
                         o.addr, o.data, o.we, o.dummy, o.lerr, o.rerr, e.addr, e.data, e.we, e.dummy, e.lerr, e.rerr);
            end else begin
                $display("wb rd=%0d data=%h we=%b dummy=%b lerr=%b rverr=%b ok", o.addr, o.data, o.we, o.dummy, o.lerr, o.rerr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_x0_write();
        test_stray_resp();
        test_load(1'b0, 5'd10, 32'h12345678);
        test_load(1'b1, 5'd11, 32'hCAFE0000);
        test_rv32e();
        test_reset_in_wait();
        test_scoreboard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
